// File: rtl/mac_compat_dpram_if.sv
// Host/TX bus bundle for the MAC-compatible packet buffer.
// Host side drives writes and the read address; the buffer returns data and start trigger.
interface mac_compat_dpram_if #(
    parameter int mac_aw = 10
);
    logic [mac_aw:0]   host_waddr;
    logic              host_write;
    logic [15:0]       host_wdata;
    logic [mac_aw-1:0] host_raddr;
    logic [15:0]       host_rdata;
    logic [mac_aw-1:0] buf_start_addr;
    logic              tx_mac_start;

    modport master (
        output host_waddr,
        output host_write,
        output host_wdata,
        output host_raddr,
        input  host_rdata,
        input  buf_start_addr,
        input  tx_mac_start
    );

    modport slave (
        input  host_waddr,
        input  host_write,
        input  host_wdata,
        input  host_raddr,
        output host_rdata,
        output buf_start_addr,
        output tx_mac_start
    );
endinterface

// File: rtl/mac_compat_dpram.sv
// Host packet buffer plus transmit-start shim feeding the MAC TX path.
// One write port, one registered read port; control space latches start address.
module mac_compat_dpram #(
    parameter int mac_aw = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    mac_compat_dpram_if.slave   bus
);
    localparam int DEPTH = 1 << mac_aw;

    logic [15:0]       mem [DEPTH] = '{default: 16'h0000};
    logic [15:0]       rdata_q;
    logic [mac_aw-1:0] start_addr_q;
    logic              start_q;
    logic              sel_ctl;
    logic              buf_we;
    logic              ctl_we;
    logic [mac_aw-1:0] waddr_w;

    always_comb begin
        sel_ctl = bus.host_waddr[mac_aw];
        waddr_w = bus.host_waddr[mac_aw-1:0];
        buf_we  = bus.host_write & ~sel_ctl;
        ctl_we  = bus.host_write & sel_ctl;
    end

    // Contents survive reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (rst_n && buf_we) begin
            mem[waddr_w] <= bus.host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 16'h0000;
        end else begin
            rdata_q <= mem[bus.host_raddr];
        end
    end

    // Every control-space address aliases onto this register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_addr_q <= '0;
            start_q      <= 1'b0;
        end else begin
            start_q <= ctl_we;
            if (ctl_we) begin
                start_addr_q <= bus.host_wdata[mac_aw-1:0];
            end
        end
    end

    assign bus.host_rdata     = rdata_q;
    assign bus.buf_start_addr = start_addr_q;
    assign bus.tx_mac_start   = start_q;
endmodule

// File: tb/tb_mac_compat_dpram.sv
// Directed, table-driven bench for mac_compat_dpram.
// Each row's expected outputs are those seen just after that row's clock edge.
module tb_mac_compat_dpram;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mac_compat_dpram_if #(.mac_aw(10)) bus ();

    mac_compat_dpram #(.mac_aw(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [10:0] waddr;
        logic [15:0] wdata;
        logic [9:0]  raddr;
        logic [15:0] e_rdata;
        logic [9:0]  e_sa;
        logic        e_st;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t v [26];

    task automatic chk(input string nm, input int row, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [10:0] wa,
                         input logic [15:0] wd, input logic [9:0] ra);
        rst_n           = r;
        bus.host_write  = w;
        bus.host_waddr  = wa;
        bus.host_wdata  = wd;
        bus.host_raddr  = ra;
    endtask

    initial begin
        // rst wr waddr wdata raddr | rdata sa st
        v[0]  = '{0, 0, 11'h000, 16'h0000, 10'h000, 16'h0000, 10'h000, 0};
        v[1]  = '{0, 0, 11'h000, 16'h0000, 10'h000, 16'h0000, 10'h000, 0};
        v[2]  = '{0, 0, 11'h000, 16'h0000, 10'h000, 16'h0000, 10'h000, 0};
        v[3]  = '{1, 0, 11'h000, 16'h0000, 10'h000, 16'h0000, 10'h000, 0};
        v[4]  = '{1, 1, 11'h005, 16'h1234, 10'h005, 16'h0000, 10'h000, 0};
        v[5]  = '{1, 1, 11'h3FF, 16'hBEEF, 10'h005, 16'h1234, 10'h000, 0};
        v[6]  = '{1, 0, 11'h000, 16'h0000, 10'h3FF, 16'hBEEF, 10'h000, 0};
        v[7]  = '{1, 0, 11'h000, 16'h0000, 10'h123, 16'h0000, 10'h000, 0};
        v[8]  = '{1, 1, 11'h400, 16'hF120, 10'h000, 16'h0000, 10'h120, 1};
        v[9]  = '{1, 0, 11'h000, 16'h0000, 10'h000, 16'h0000, 10'h120, 0};
        v[10] = '{1, 1, 11'h7FF, 16'h0055, 10'h3FF, 16'hBEEF, 10'h055, 1};
        v[11] = '{1, 0, 11'h000, 16'h0000, 10'h3FF, 16'hBEEF, 10'h055, 0};
        v[12] = '{1, 1, 11'h400, 16'h0010, 10'h000, 16'h0000, 10'h010, 1};
        v[13] = '{1, 1, 11'h401, 16'h0020, 10'h000, 16'h0000, 10'h020, 1};
        v[14] = '{1, 0, 11'h000, 16'h0000, 10'h000, 16'h0000, 10'h020, 0};
        v[15] = '{1, 1, 11'h008, 16'h1111, 10'h008, 16'h0000, 10'h020, 0};
        v[16] = '{1, 1, 11'h008, 16'h2222, 10'h008, 16'h1111, 10'h020, 0};
        v[17] = '{1, 0, 11'h000, 16'h0000, 10'h008, 16'h2222, 10'h020, 0};
        v[18] = '{1, 1, 11'h00A, 16'hAAAA, 10'h005, 16'h1234, 10'h020, 0};
        v[19] = '{1, 0, 11'h000, 16'h0000, 10'h00A, 16'hAAAA, 10'h020, 0};
        v[20] = '{0, 1, 11'h400, 16'h0333, 10'h005, 16'h0000, 10'h000, 0};
        v[21] = '{0, 1, 11'h005, 16'hDEAD, 10'h005, 16'h0000, 10'h000, 0};
        v[22] = '{1, 0, 11'h000, 16'h0000, 10'h005, 16'h1234, 10'h000, 0};
        v[23] = '{1, 0, 11'h000, 16'h0000, 10'h00A, 16'hAAAA, 10'h000, 0};
        v[24] = '{1, 1, 11'h5A5, 16'h0077, 10'h000, 16'h0000, 10'h077, 1};
        v[25] = '{0, 0, 11'h000, 16'h0000, 10'h000, 16'h0000, 10'h000, 0};

        drive(0, 0, 11'h000, 16'h0000, 10'h000);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(v[i].rst_n, v[i].wr, v[i].waddr, v[i].wdata, v[i].raddr);
            @(posedge clk);
            #1;
            chk("rdata", i, int'(bus.host_rdata), int'(v[i].e_rdata));
            chk("start_addr", i, int'(bus.buf_start_addr), int'(v[i].e_sa));
            chk("tx_start", i, int'(bus.tx_mac_start), int'(v[i].e_st));
        end

        // Single control write must yield exactly one pulse within a bounded window.
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            drive(1, 1, 11'h6AB, 16'hC3C5, 10'h000);
            @(negedge clk);
            drive(1, 0, 11'h000, 16'h0000, 10'h000);
            if (bus.tx_mac_start === 1'b1) pulses++;
            chk("seq_sa", 100, int'(bus.buf_start_addr), 32'h3C5);
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.tx_mac_start === 1'b1) pulses++;
            end
            chk("seq_pulse_count", 100, pulses, 1);
            chk("seq_sa_hold", 100, int'(bus.buf_start_addr), 32'h3C5);
        end

        // Wrap: address 0x3FF and 0x000 are distinct; control space never touches memory.
        begin
            @(negedge clk);
            drive(1, 1, 11'h000, 16'h5A5A, 10'h3FF);
            @(negedge clk);
            drive(1, 1, 11'h400, 16'h0000, 10'h000);
            chk("wrap_rd3ff", 101, int'(bus.host_rdata), 32'hBEEF);
            @(negedge clk);
            drive(1, 0, 11'h000, 16'h0000, 10'h000);
            chk("wrap_rd000", 101, int'(bus.host_rdata), 32'h5A5A);
            chk("wrap_st", 101, int'(bus.tx_mac_start), 1);
            @(negedge clk);
            chk("wrap_rd000_after_ctl", 101, int'(bus.host_rdata), 32'h5A5A);
            chk("wrap_st_off", 101, int'(bus.tx_mac_start), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mac_compat_dpram.md
Name: mac_compat_dpram

Overview:
- Host-side packet buffer plus transmit-trigger shim that feeds the MAC transmit path in rtefi_blob.
- Host writes 16-bit words into a 2^mac_aw-word buffer memory. A write to the control half of the address space latches a buffer start address and pulses a start strobe.
- The MAC transmitter reads the buffer through a synchronous read port.
- Host and TX sides share one clock.

Parameters:
- mac_aw, 10: buffer word-address width; memory depth 2^mac_aw words of 16 bits.

Ports:
- clk  input  1  single clock for host write side and TX read side (host_clk and tx_clk tied together).
- rst_n  input  1  reset, synchronous, active-low.
- host_waddr  input  mac_aw+1  write address; bit [mac_aw] selects space: 0 = buffer memory, 1 = control.
- host_write  input  1  write strobe, one cycle per word.
- host_wdata  input  16  write data.
- host_raddr  input  mac_aw  TX-side read word address.
- host_rdata  output  16  TX-side read data.
- buf_start_addr  output  mac_aw  latched packet start address for the MAC.
- tx_mac_start  output  1  one-cycle transmit start pulse.

Behaviour:
- Memory: 2^mac_aw x 16 words, initialised to 0 at configuration/simulation start. rst_n does not clear memory contents.
- Buffer write: on a rising edge with host_write=1 and host_waddr[mac_aw]=0, set mem[host_waddr[mac_aw-1:0]] <= host_wdata.
- Control write: on a rising edge with host_write=1 and host_waddr[mac_aw]=1:
  - buf_start_addr <= host_wdata[mac_aw-1:0]; host_wdata[15:mac_aw] are ignored.
  - tx_mac_start <= 1 on the same edge.
  - host_waddr[mac_aw-1:0] is ignored, so every control-space address aliases to the one register.
  - No memory write occurs.
- tx_mac_start timing:
  - Goes high the cycle after the control write and lasts exactly one cycle.
  - buf_start_addr already holds its new value in that same cycle.
  - Back-to-back control writes give tx_mac_start high for consecutive cycles; buf_start_addr follows each write.
- Idle hold: with host_write=0, buf_start_addr holds its value and tx_mac_start=0.
- Read port:
  - Synchronous, 1-cycle latency: host_rdata <= mem[host_raddr] every edge.
  - No read enable; host_rdata updates every cycle.
- Read-during-write to the same address: host_rdata returns the old (pre-write) data; the new data is visible on the next read.
- Simultaneous buffer write and read at different addresses proceed independently.
- Reset (rst_n=0 at a rising edge):
  - buf_start_addr=0, tx_mac_start=0, host_rdata=0.
  - Host writes of both kinds are ignored while rst_n=0.
  - A start pulse in flight is cleared.
- Address wrap: buffer addresses are taken modulo 2^mac_aw; there is no out-of-range case.
- No combinational paths from inputs to outputs; all outputs registered.
- Synthesis: memory infers a simple dual-port block RAM (one write port, one registered read port).

Test Plan:
1. Reset then idle:
   - rst_n=0 for 3 cycles, then release -> buf_start_addr=0, tx_mac_start=0, host_rdata=0 throughout.
   - Release with no writes -> no start pulse.
2. Buffer fill and readback:
   - Write 0x1234 to waddr 0x005 and 0xBEEF to 0x3FF (mac_aw=10).
   - Set raddr=0x005 -> host_rdata=0x1234 one cycle later.
   - Set raddr=0x3FF -> host_rdata=0xBEEF.
   - Unwritten address -> 0x0000.
3. Start trigger:
   - Write wdata=0xF120 to waddr 0x400 -> the next cycle has buf_start_addr=0x120 and tx_mac_start=1 for exactly one cycle.
   - Memory word 0x000 is unchanged.
   - Repeat with waddr 0x7FF -> same behaviour.
4. Back-to-back control writes:
   - Write 0x010 then 0x020 on consecutive cycles -> tx_mac_start high 2 cycles.
   - buf_start_addr reads 0x010, then 0x020.
5. Read-during-write:
   - mem[0x008]=0x1111; write 0x2222 to 0x008 with raddr=0x008 in the same cycle -> host_rdata=0x1111, then 0x2222 the following cycle.
6. Reset mid-operation:
   - Control write on the same edge as rst_n=0 -> no tx_mac_start pulse, buf_start_addr=0.
   - Buffer write during reset -> memory unchanged.
